mod_addsub_pipe: RTL and testbench

Parametrised, pipelined dual-mode modular adder/subtractor for the Kyber/Dilithium NTT datapath. Each lane produces both (a+b) mod q and (a-b) mod q in parallel. A lane operates as two independent 12-bit Kyber halves (q=KQ) or one 24-bit Dilithium word (q=DQ). Configurable-depth operand alignment delay lines, valid/ready flow control and a 2-stage pipeline make it a drop-in butterfly add/sub unit for multi-lane PE arrays.

---
 rtl/mod_addsub_pipe.sv | 146 ++++++++++++++
 tb/tb_mod_addsub_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mod_addsub_pipe.sv
// Dual-mode (Kyber 2x12-bit / Dilithium 24-bit) modular add/sub lane array.
// Two-stage pipeline with per-operand alignment delay lines and valid/ready flow control.
module mod_addsub_pipe #(
   parameter int LANES   = 2,
   parameter int KQ      = 3329,
   parameter int DQ      = 8380417,
   parameter int DELAY_A = 6,
   parameter int DELAY_B = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                kd_mode,
   input  logic                dly_a_en,
   input  logic                dly_b_en,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [24*LANES-1:0] a,
   input  logic [24*LANES-1:0] b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [24*LANES-1:0] out_sum,
   output logic [24*LANES-1:0] out_diff
);

   localparam int W = 24 * LANES;
   localparam logic [12:0] KQ13 = 13'(KQ);
   localparam logic [24:0] DQ25 = 25'(DQ);

   logic stall, accept, adv;
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;
   assign accept   = in_valid & in_ready;
   assign adv      = ~stall;

   logic [W-1:0] dla [DELAY_A];
   logic [W-1:0] dlb [DELAY_B];

   // Delay lines advance only on accepted beats, so depth is counted in beats, not cycles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DELAY_A; i++) dla[i] <= '0;
         for (int unsigned i = 0; i < DELAY_B; i++) dlb[i] <= '0;
      end else if (accept) begin
         dla[0] <= a;
         dlb[0] <= b;
         for (int unsigned i = 1; i < DELAY_A; i++) dla[i] <= dla[i-1];
         for (int unsigned i = 1; i < DELAY_B; i++) dlb[i] <= dlb[i-1];
      end
   end

   logic [W-1:0] eff_a, eff_b;
   assign eff_a = dly_a_en ? dla[DELAY_A-1] : a;
   assign eff_b = dly_b_en ? dlb[DELAY_B-1] : b;

   logic [LANES-1:0][12:0] ks_lo, ks_hi, kd_lo, kd_hi;
   logic [LANES-1:0][24:0] ds, dd;

   always_comb begin
      ks_lo = '0;
      ks_hi = '0;
      kd_lo = '0;
      kd_hi = '0;
      ds    = '0;
      dd    = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         ks_lo[l] = {1'b0, eff_a[24*l +: 12]} + {1'b0, eff_b[24*l +: 12]};
         kd_lo[l] = {1'b0, eff_a[24*l +: 12]} - {1'b0, eff_b[24*l +: 12]};
         ks_hi[l] = {1'b0, eff_a[24*l+12 +: 12]} + {1'b0, eff_b[24*l+12 +: 12]};
         kd_hi[l] = {1'b0, eff_a[24*l+12 +: 12]} - {1'b0, eff_b[24*l+12 +: 12]};
         ds[l]    = {1'b0, eff_a[24*l +: 24]} + {1'b0, eff_b[24*l +: 24]};
         dd[l]    = {1'b0, eff_a[24*l +: 24]} - {1'b0, eff_b[24*l +: 24]};
      end
   end

   logic                   s1_valid, s1_mode;
   logic [LANES-1:0][12:0] s1_ks_lo, s1_ks_hi, s1_kd_lo, s1_kd_hi;
   logic [LANES-1:0][24:0] s1_ds, s1_dd;

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_mode  <= 1'b0;
         s1_ks_lo <= '0;
         s1_ks_hi <= '0;
         s1_kd_lo <= '0;
         s1_kd_hi <= '0;
         s1_ds    <= '0;
         s1_dd    <= '0;
      end else if (adv) begin
         s1_valid <= accept;
         s1_mode  <= kd_mode;
         s1_ks_lo <= ks_lo;
         s1_ks_hi <= ks_hi;
         s1_kd_lo <= kd_lo;
         s1_kd_hi <= kd_hi;
         s1_ds    <= ds;
         s1_dd    <= dd;
      end
   end

   logic [W-1:0] nxt_sum, nxt_diff;
   logic [12:0]  t_slo, t_shi, t_dlo, t_dhi;
   logic [24:0]  t_sd, t_dd;

   // Single conditional correction: raw sum < 2q and raw diff > -q for reduced inputs.
   always_comb begin
      nxt_sum  = '0;
      nxt_diff = '0;
      t_slo    = '0;
      t_shi    = '0;
      t_dlo    = '0;
      t_dhi    = '0;
      t_sd     = '0;
      t_dd     = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         t_slo = (s1_ks_lo[l] >= KQ13) ? s1_ks_lo[l] - KQ13 : s1_ks_lo[l];
         t_shi = (s1_ks_hi[l] >= KQ13) ? s1_ks_hi[l] - KQ13 : s1_ks_hi[l];
         t_dlo = s1_kd_lo[l][12] ? s1_kd_lo[l] + KQ13 : s1_kd_lo[l];
         t_dhi = s1_kd_hi[l][12] ? s1_kd_hi[l] + KQ13 : s1_kd_hi[l];
         t_sd  = (s1_ds[l] >= DQ25) ? s1_ds[l] - DQ25 : s1_ds[l];
         t_dd  = s1_dd[l][24] ? s1_dd[l] + DQ25 : s1_dd[l];
         if (s1_mode) begin
            nxt_sum[24*l +: 24]  = t_sd[23:0];
            nxt_diff[24*l +: 24] = t_dd[23:0];
         end else begin
            nxt_sum[24*l +: 24]  = {t_shi[11:0], t_slo[11:0]};
            nxt_diff[24*l +: 24] = {t_dhi[11:0], t_dlo[11:0]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_diff  <= '0;
      end else if (adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_sum  <= nxt_sum;
            out_diff <= nxt_diff;
         end
      end
   end

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Self-checking bench for mod_addsub_pipe: directed vectors plus randomized traffic
// scored against a beat-level arithmetic reference model.
module tb_mod_addsub_pipe;

   localparam int LANES   = 2;
   localparam int KQ      = 3329;
   localparam int DQ      = 8380417;
   localparam int DELAY_A = 6;
   localparam int DELAY_B = 7;
   localparam int W       = 24 * LANES;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         kd_mode = 1'b0, dly_a_en = 1'b0, dly_b_en = 1'b0;
   logic         in_valid = 1'b0, out_ready = 1'b1;
   logic         in_ready, out_valid;
   logic [W-1:0] a = '0, b = '0;
   logic [W-1:0] out_sum, out_diff;

   mod_addsub_pipe #(.LANES(LANES), .KQ(KQ), .DQ(DQ), .DELAY_A(DELAY_A), .DELAY_B(DELAY_B)) dut (
      .clk(clk), .rst(rst), .kd_mode(kd_mode), .dly_a_en(dly_a_en), .dly_b_en(dly_b_en),
      .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_diff(out_diff)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   bit auto_release = 1'b1;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   function automatic logic [W-1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic mode, input bit is_sum);
      logic [W-1:0] r = '0;
      longint s, q;
      for (int l = 0; l < LANES; l++) begin
         if (mode) begin
            q = DQ;
            s = is_sum ? longint'(x[24*l +: 24]) + longint'(y[24*l +: 24])
                       : longint'(x[24*l +: 24]) - longint'(y[24*l +: 24]);
            if (is_sum && s >= q) s -= q;
            if (!is_sum && s < 0) s += q;
            r[24*l +: 24] = s[23:0];
         end else begin
            q = KQ;
            for (int h = 0; h < 2; h++) begin
               s = is_sum ? longint'(x[24*l+12*h +: 12]) + longint'(y[24*l+12*h +: 12])
                          : longint'(x[24*l+12*h +: 12]) - longint'(y[24*l+12*h +: 12]);
               if (is_sum && s >= q) s -= q;
               if (!is_sum && s < 0) s += q;
               r[24*l+12*h +: 12] = s[11:0];
            end
         end
      end
      return r;
   endfunction

   logic [W-1:0] hist_a[$], hist_b[$], exp_s[$], exp_d[$], got_sum[$];
   logic [W-1:0] prev_sum, prev_diff;
   bit           prev_stall = 1'b0;

   // Model: accepted beats recorded at the negedge before the accepting edge.
   always @(negedge clk) begin
      logic [W-1:0] ea, eb, es, ed;
      if (!rst) begin
         hist_a.delete(); hist_b.delete(); exp_s.delete(); exp_d.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", W'(out_valid), W'(1));
            check("hold_sum", out_sum, prev_sum);
            check("hold_diff", out_diff, prev_diff);
         end
         if (out_valid && !out_ready) check("in_ready_stall", W'(in_ready), W'(0));
         if (out_valid && out_ready) begin
            if (exp_s.size() == 0) check("spurious_out", W'(1), W'(0));
            else begin
               es = exp_s.pop_front();
               ed = exp_d.pop_front();
               check("sum", out_sum, es);
               check("diff", out_diff, ed);
            end
            got_sum.push_back(out_sum);
         end
         prev_stall = out_valid && !out_ready;
         prev_sum   = out_sum;
         prev_diff  = out_diff;
         if (in_valid && in_ready) begin
            ea = a;
            eb = b;
            if (dly_a_en) ea = (hist_a.size() >= DELAY_A) ? hist_a[hist_a.size()-DELAY_A] : '0;
            if (dly_b_en) eb = (hist_b.size() >= DELAY_B) ? hist_b[hist_b.size()-DELAY_B] : '0;
            exp_s.push_back(ref_op(ea, eb, kd_mode, 1'b1));
            exp_d.push_back(ref_op(ea, eb, kd_mode, 1'b0));
            hist_a.push_back(a);
            hist_b.push_back(b);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic beat(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic m, input logic da, input logic db);
      a = av; b = bv; kd_mode = m; dly_a_en = da; dly_b_en = db; in_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         if (in_ready) break;
         @(posedge clk); #1;
         if (k >= 1 && auto_release) out_ready = 1'b1;
      end
      if (!in_ready) check("accept_timeout", W'(in_ready), W'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int k = 0; k < 100 && exp_s.size() != 0; k++) begin
         @(posedge clk); #1;
      end
      check("drain", W'(exp_s.size()), W'(0));
   endtask

   task automatic do_reset();
      rst = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      check("rst_valid", W'(out_valid), W'(0));
      check("rst_sum", out_sum, '0);
      check("rst_diff", out_diff, '0);
      check("rst_ready", W'(in_ready), W'(1));
      rst = 1'b1;
   endtask

   task automatic directed(input logic [W-1:0] av, input logic [W-1:0] bv, input logic m,
                           input logic [W-1:0] xs, input logic [W-1:0] xd);
      out_ready = 1'b1;
      beat(av, bv, m, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("dir_valid", W'(out_valid), W'(1));
      check("dir_sum", out_sum, xs);
      check("dir_diff", out_diff, xd);
   endtask

   function automatic logic [W-1:0] rand_op(input logic m);
      logic [W-1:0] v = '0;
      for (int l = 0; l < LANES; l++) begin
         if (m) v[24*l +: 24] = 24'($urandom_range(DQ-1, 0));
         else v[24*l +: 24] = {12'($urandom_range(KQ-1, 0)), 12'($urandom_range(KQ-1, 0))};
      end
      return v;
   endfunction

   initial begin
      logic [W-1:0] g;
      @(posedge clk); #1;
      do_reset();

      directed({24'd0, 12'd3000, 12'd100}, {24'd0, 12'd500, 12'd200}, 1'b0,
               {24'd0, 12'd171, 12'd300}, {24'd0, 12'd2500, 12'd3229});
      directed({24'd0, 24'd8380000}, {24'd0, 24'd1000}, 1'b1,
               {24'd0, 24'd583}, {24'd0, 24'd8379000});
      directed({24'd5, 24'd5}, {24'd10, 24'd10}, 1'b1,
               {24'd15, 24'd15}, {24'd8380412, 24'd8380412});
      directed({24'd0, 24'd4194208}, {24'd0, 24'd4194208}, 1'b1,
               {24'd0, 24'd7999}, {24'd0, 24'd0});
      drain();

      // Delay line on b, Kyber lo half carries the beat index.
      do_reset();
      got_sum.delete();
      for (int i = 1; i <= 10; i++) beat('0, W'(i), 1'b0, 1'b0, 1'b1);
      drain();
      check("dly_count", W'(got_sum.size()), W'(10));
      if (got_sum.size() == 10) begin
         g = got_sum[6]; check("dly_beat7", W'(g[11:0]), W'(0));
         g = got_sum[7]; check("dly_beat8", W'(g[11:0]), W'(1));
         g = got_sum[9]; check("dly_beat10", W'(g[11:0]), W'(3));
      end

      // Backpressure window during a continuous stream.
      auto_release = 1'b0;
      fork
         for (int i = 0; i < 10; i++) beat(rand_op(1'b0), rand_op(1'b0), 1'b0, i[0], 1'b1);
         begin
            repeat (4) @(posedge clk); #1;
            out_ready = 1'b0;
            repeat (3) @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      auto_release = 1'b1;
      drain();

      // Mode interleave.
      for (int i = 0; i < 12; i++) begin
         kd_mode = i[0];
         beat(rand_op(i[0]), rand_op(i[0]), i[0], 1'b0, 1'b0);
      end
      drain();

      // Reset with beats in flight, then random traffic exercising refill of delay lines.
      beat(rand_op(1'b1), rand_op(1'b1), 1'b1, 1'b0, 1'b0);
      beat(rand_op(1'b1), rand_op(1'b1), 1'b1, 1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < 200; i++) begin
         logic m;
         m = 1'($urandom_range(1, 0));
         out_ready = ($urandom_range(3, 0) != 0);
         beat(rand_op(m), rand_op(m), m, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

endmodule
